// File: rtl/clk_divider_pkg.sv
// -----------------------------------------------------------------------------
// clk_divider_pkg
//   Elaboration-time helpers for the integer clock divider.
//   round_div     : nearest-integer ratio FREQ_IN/FREQ_OUT (0 when FREQ_OUT is 0,
//                   so the caller can report the bad setting instead of dividing
//                   by zero during elaboration).
//   counter_width : max(1, $clog2(div)), the width of the period counter.
// -----------------------------------------------------------------------------
package clk_divider_pkg;

  function automatic int unsigned round_div(input int unsigned freq_in,
                                            input int unsigned freq_out);
    if (freq_out == 0) return 0;
    return (freq_in + freq_out / 2) / freq_out;
  endfunction

  function automatic int unsigned counter_width(input int unsigned div);
    int w;
    w = $clog2(div);
    return (w < 1) ? 1 : int'(w);
  endfunction

endpackage

// File: rtl/clk_divider_if.sv
// -----------------------------------------------------------------------------
// clk_divider_if
//   Output bundle of the clock divider.
//   clk_out : divided square-wave clock (registered, glitch-free)
//   tick    : one clk_in-cycle strobe, high in the cycle clk_out first reads 1
//   master  : driven by the divider
//   slave   : consumers in the clk_in domain (prefer tick as a clock enable)
// -----------------------------------------------------------------------------
interface clk_divider_if;
  logic clk_out;
  logic tick;

  modport master (output clk_out, output tick);
  modport slave  (input  clk_out, input  tick);
endinterface

// File: rtl/clk_divider.sv
// -----------------------------------------------------------------------------
// clk_divider
//   Derives a square wave of period DIV clk_in cycles, DIV = round(FREQ_IN /
//   FREQ_OUT). The output is low for LOW = floor(DIV/2) cycles and high for the
//   remaining DIV-LOW cycles (one extra high cycle for odd DIV). A tick strobe
//   marks the first high cycle of every period.
//
//   Parameters
//     FREQ_IN  : input clock frequency in Hz
//     FREQ_OUT : requested output frequency in Hz
//   Ports
//     clk_in   : system clock, rising edge
//     rst      : asynchronous, active-high reset
//     div_if   : master side of clk_divider_if (clk_out, tick)
//
//   If clk_out is used as a real clock it must be constrained as a generated
//   clock; otherwise consume tick as an enable in the clk_in domain.
// -----------------------------------------------------------------------------
module clk_divider
  import clk_divider_pkg::*;
#(
  parameter int unsigned FREQ_IN  = 12000000,
  parameter int unsigned FREQ_OUT = 9600
) (
  input  logic          clk_in,
  input  logic          rst,
  clk_divider_if.master div_if
);

  localparam int unsigned DIV = round_div(FREQ_IN, FREQ_OUT);
  localparam int unsigned LOW = DIV / 2;
  localparam int unsigned CW  = counter_width(DIV);

  localparam logic [CW-1:0] LAST_C = CW'(DIV - 1);
  localparam logic [CW-1:0] LOW_C  = CW'(LOW);

  if (FREQ_OUT == 0) begin : g_bad_freq_out
    $fatal(1, "clk_divider: FREQ_OUT must be non-zero");
  end
  if (FREQ_OUT != 0 && DIV < 2) begin : g_bad_div
    $fatal(1, "clk_divider: division ratio below 2 is not supported");
  end

  logic [CW-1:0] cnt_q,     cnt_d;
  logic          clk_out_q, clk_out_d;
  logic          tick_q,    tick_d;

  // Outputs are decoded from the *next* count and registered, so clk_out is a
  // clean flop output that already reflects the count it belongs to.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave
    // it unassigned and infer a latch.
    cnt_d     = '0;
    clk_out_d = 1'b0;
    tick_d    = 1'b0;

    if (cnt_q != LAST_C) cnt_d = cnt_q + CW'(1);
    clk_out_d = (cnt_d >= LOW_C);
    tick_d    = (cnt_d == LOW_C);
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      // NOTE: state flops use non-blocking assignment so all registers sample
      // the same pre-edge values regardless of statement order.
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign div_if.clk_out = clk_out_q;
  assign div_if.tick    = tick_q;

endmodule

// File: tb/tb_clk_divider.sv
// -----------------------------------------------------------------------------
// tb_clk_divider
//   Directed bench for clk_divider. Four instances share clk_in/rst:
//     u_def : 12 MHz / 9600 -> DIV 1250 (625 low, 625 high)
//     u_min : 2 / 1         -> DIV 2    (0,1,0,1 ...)
//     u_odd : 3 / 1         -> DIV 3    (0,1,1 ...)
//     u_rnd : 100 / 30      -> DIV 3    ((100+15)/30)
//   Outputs are sampled 1 ns after each rising edge of clk_in.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_clk_divider;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;

  always #5 clk_in = ~clk_in;

  clk_divider_if def_if ();
  clk_divider_if min_if ();
  clk_divider_if odd_if ();
  clk_divider_if rnd_if ();

  clk_divider #(.FREQ_IN(12000000), .FREQ_OUT(9600)) u_def (.clk_in(clk_in), .rst(rst), .div_if(def_if));
  clk_divider #(.FREQ_IN(2),        .FREQ_OUT(1))    u_min (.clk_in(clk_in), .rst(rst), .div_if(min_if));
  clk_divider #(.FREQ_IN(3),        .FREQ_OUT(1))    u_odd (.clk_in(clk_in), .rst(rst), .div_if(odd_if));
  clk_divider #(.FREQ_IN(100),      .FREQ_OUT(30))   u_rnd (.clk_in(clk_in), .rst(rst), .div_if(rnd_if));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic edge_sample();
    @(posedge clk_in);
    #1;
  endtask

  // Hand-computed per-edge patterns after reset release; bit (e-1) is edge e.
  logic [5:0] min_clk_exp  = 6'b010101;  // 1,0,1,0,1,0
  logic [5:0] min_tick_exp = 6'b010101;  // tick with every rise
  logic [5:0] odd_clk_exp  = 6'b011011;  // 1,1,0,1,1,0
  logic [5:0] odd_tick_exp = 6'b001001;  // 1,0,0,1,0,0

  initial begin
    int def_first_rise, def_fall, def_second_rise, def_rises, def_ticks, def_stray;
    int rnd_rise1, rnd_rise2;
    int n, rises, ticks, bad_period, stray, last_rise;
    logic prev_def, prev_rnd, rise;

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_def_clk",  def_if.clk_out, 0);
    check("rst_def_tick", def_if.tick,    0);
    check("rst_def_cnt",  32'(u_def.cnt_q), 0);
    check("rst_min_clk",  min_if.clk_out, 0);
    check("rst_min_tick", min_if.tick,    0);
    check("rst_odd_clk",  odd_if.clk_out, 0);
    check("rst_odd_tick", odd_if.tick,    0);
    check("rst_rnd_clk",  rnd_if.clk_out, 0);
    check("rst_rnd_tick", rnd_if.tick,    0);
    @(negedge clk_in);
    rst = 1'b0;

    // ---------------- two default periods + small-ratio patterns ----------------
    def_first_rise = -1; def_fall = -1; def_second_rise = -1;
    def_rises = 0; def_ticks = 0; def_stray = 0;
    rnd_rise1 = -1; rnd_rise2 = -1;
    prev_def = 1'b0; prev_rnd = 1'b0;
    for (int e = 1; e <= 2500; e++) begin
      edge_sample();
      if (e <= 6) begin
        check($sformatf("min_clk_e%0d",  e), min_if.clk_out, min_clk_exp[e-1]);
        check($sformatf("min_tick_e%0d", e), min_if.tick,    min_tick_exp[e-1]);
        check($sformatf("odd_clk_e%0d",  e), odd_if.clk_out, odd_clk_exp[e-1]);
        check($sformatf("odd_tick_e%0d", e), odd_if.tick,    odd_tick_exp[e-1]);
        check($sformatf("rnd_clk_e%0d",  e), rnd_if.clk_out, odd_clk_exp[e-1]);
      end
      if (rnd_if.clk_out && !prev_rnd) begin
        if (rnd_rise1 < 0) rnd_rise1 = e;
        else if (rnd_rise2 < 0) rnd_rise2 = e;
      end
      prev_rnd = rnd_if.clk_out;

      rise = def_if.clk_out && !prev_def;
      if (rise) begin
        def_rises++;
        if (def_first_rise < 0) def_first_rise = e;
        else if (def_second_rise < 0) def_second_rise = e;
      end
      if (!def_if.clk_out && prev_def && def_fall < 0) def_fall = e;
      if (def_if.tick) def_ticks++;
      if (def_if.tick && !rise) def_stray++;
      prev_def = def_if.clk_out;
    end
    check("def_first_rise_edge",  def_first_rise, 625);
    check("def_first_fall_edge",  def_fall, 1250);
    check("def_second_rise_edge", def_second_rise, 1875);
    check("def_rises_2500",       def_rises, 2);
    check("def_ticks_2500",       def_ticks, 2);
    check("def_tick_not_on_rise", def_stray, 0);
    check("rnd_period",           rnd_rise2 - rnd_rise1, 3);
    check("rnd_first_rise_edge",  rnd_rise1, 1);

    // ---------------- asynchronous reset while clk_out is high ----------------
    repeat (1000) edge_sample();           // count 3500 mod 1250 = 1000, high phase
    check("pre_rst_def_high", def_if.clk_out, 1);
    #2;                                    // between edges
    rst = 1'b1;
    #1;
    check("mid_rst_def_clk",  def_if.clk_out, 0);
    check("mid_rst_def_tick", def_if.tick,    0);
    check("mid_rst_def_cnt",  32'(u_def.cnt_q), 0);
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst = 1'b0;
    n = 0;
    do begin
      edge_sample();
      n++;
    end while (!def_if.clk_out && n < 2000);
    check("post_rst_first_rise", n, 625);
    check("post_rst_tick_at_rise", def_if.tick, 1);

    // ---------------- long run: 40 periods from a rise ----------------
    rises = 0; ticks = 0; bad_period = 0; stray = 0; last_rise = 0;
    prev_def = def_if.clk_out;
    for (int e = 1; e <= 40 * 1250; e++) begin
      edge_sample();
      rise = def_if.clk_out && !prev_def;
      if (rise) begin
        rises++;
        if (e - last_rise != 1250) bad_period++;
        last_rise = e;
      end
      if (def_if.tick) ticks++;
      if (def_if.tick && !rise) stray++;
      prev_def = def_if.clk_out;
    end
    check("long_rises",       rises, 40);
    check("long_ticks",       ticks, 40);
    check("long_bad_periods", bad_period, 0);
    check("long_stray_ticks", stray, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
